// File: rtl/seg7_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_driver
//  Description : Converts a signed 32-bit result to BCD (sequential
//                double-dabble), formats it with leading-zero blanking,
//                minus sign and overflow "Err", and scans it onto an
//                8-digit common-anode 7-segment display.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_display_driver #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLANK_ZEROS = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] value_i,
  input  logic        update_i,
  output logic        busy_o,
  output logic        ovf_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  // Conversion FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Internal digit symbols: 0..9 are decimal digits, the rest are glyphs
  localparam logic [3:0] SYM_MINUS = 4'hA;
  localparam logic [3:0] SYM_E     = 4'hB;
  localparam logic [3:0] SYM_R     = 4'hC;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  localparam int             CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic             sign_q;
  logic [31:0]      mag_q;
  logic [39:0]      bcd_q;
  logic [4:0]       bit_cnt_q;
  logic             pending_q;
  logic             busy_q;
  logic             ovf_q;
  logic [7:0][3:0]  digit_q;

  logic [CNT_W-1:0] scan_cnt_q;
  logic [2:0]       scan_idx_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;

  logic             start;
  logic             shift_en;
  logic             commit;
  logic [39:0]      bcd_adj;
  logic             ovf_fmt;
  int               msd;
  logic [7:0][3:0]  digit_fmt;

  // Symbol to active-low gfedcba segment pattern
  function automatic logic [6:0] sym_to_seg(input logic [3:0] sym);
    logic [6:0] s;
    case (sym)
      4'd0:      s = 7'b1000000;
      4'd1:      s = 7'b1111001;
      4'd2:      s = 7'b0100100;
      4'd3:      s = 7'b0110000;
      4'd4:      s = 7'b0011001;
      4'd5:      s = 7'b0010010;
      4'd6:      s = 7'b0000010;
      4'd7:      s = 7'b1111000;
      4'd8:      s = 7'b0000000;
      4'd9:      s = 7'b0010000;
      SYM_MINUS: s = 7'b0111111;
      SYM_E:     s = 7'b0000110;
      SYM_R:     s = 7'b0101111;
      default:   s = 7'b1111111;
    endcase
    return s;
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic: CONV runs for exactly 32 shifts, COMMIT for one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (update_i || pending_q) state_d = S_CONV;
      S_CONV:   if (bit_cnt_q == 5'd31)    state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: datapath control strobes
  always_comb begin
    start    = (state_q == S_IDLE) && (update_i || pending_q);
    shift_en = (state_q == S_CONV);
    commit   = (state_q == S_COMMIT);
  end

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Display formatting of the finished BCD value (used only at COMMIT)
  always_comb begin
    ovf_fmt   = sign_q ? (|bcd_q[39:28]) : (|bcd_q[39:32]);
    msd       = 0;
    digit_fmt = {8{SYM_BLANK}};
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) msd = i;
    end
    if (ovf_fmt) begin
      digit_fmt[2] = SYM_E;
      digit_fmt[1] = SYM_R;
      digit_fmt[0] = SYM_R;
    end else begin
      for (int i = 0; i < 8; i++) begin
        // Digit 0 is always shown since msd never drops below 0
        if ((BLANK_ZEROS == 0) || (i <= msd)) digit_fmt[i] = bcd_q[i*4 +: 4];
        // Non-overflowing negatives have at most 7 digits, so msd+1 stays in range
        if (sign_q && (i == msd + 1))         digit_fmt[i] = SYM_MINUS;
      end
    end
  end

  // Conversion datapath, status flags and committed digit registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      bcd_q     <= 40'd0;
      bit_cnt_q <= 5'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      digit_q   <= {{7{SYM_BLANK}}, 4'd0};
    end else begin
      if (start) begin
        sign_q    <= value_i[31];
        // Two's-complement negate; -2^31 maps onto 0x8000_0000 unchanged
        mag_q     <= value_i[31] ? (~value_i + 32'd1) : value_i;
        bcd_q     <= 40'd0;
        bit_cnt_q <= 5'd0;
        pending_q <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        if (update_i) pending_q <= 1'b1;
        if (shift_en) begin
          bcd_q     <= {bcd_adj[38:0], mag_q[31]};
          mag_q     <= {mag_q[30:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        if (commit) begin
          busy_q  <= 1'b0;
          ovf_q   <= ovf_fmt;
          digit_q <= digit_fmt;
        end
      end
    end
  end

  // Free-running digit scanner; an and seg are registered together
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 3'd0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      an_q  <= ~(8'd1 << scan_idx_q);
      seg_q <= sym_to_seg(digit_q[scan_idx_q]);
    end
  end

  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_driver
//  Description : Self-checking bench for seg7_display_driver. Two instances
//                (leading-zero blanking on and off) share the same stimulus;
//                results are compared against a decimal reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_display_driver;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic        update;
  logic        busy0, ovf0, dp0, busy1, ovf1, dp1;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_display_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_ZEROS(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .update_i(update),
    .busy_o(busy0), .ovf_o(ovf0), .an_o(an0), .seg_o(seg0), .dp_o(dp0)
  );

  seg7_display_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_ZEROS(0)) u_dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .value_i(value), .update_i(update),
    .busy_o(busy1), .ovf_o(ovf1), .an_o(an1), .seg_o(seg1), .dp_o(dp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Glyph table: 0..9 digits, 10 minus, 11 E, 12 r, anything else blank
  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0111111; 11: return 7'b0000110;
      12: return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Decimal reference: what the 8 digits should read for a signed value
  function automatic logic [55:0] model_frame(input logic [31:0] v, input bit bz, output bit ov);
    longint     sv, mag;
    bit         neg;
    int         dec[8];
    int         sym[8];
    int         top;
    logic [55:0] f;
    sv  = longint'(signed'(v));
    neg = (sv < 0);
    mag = neg ? -sv : sv;
    ov  = neg ? (mag > 64'sd9999999) : (mag > 64'sd99999999);
    for (int i = 0; i < 8; i++) sym[i] = 15;
    if (ov) begin
      sym[2] = 11; sym[1] = 12; sym[0] = 12;
    end else begin
      top = 0;
      for (int i = 0; i < 8; i++) begin
        dec[i] = int'(mag % 10);
        mag    = mag / 10;
        if (dec[i] != 0) top = i;
      end
      for (int i = 0; i < 8; i++) if (!bz || i <= top) sym[i] = dec[i];
      if (neg) sym[top + 1] = 10;
    end
    for (int i = 0; i < 8; i++) f[i*7 +: 7] = seg_code(sym[i]);
    return f;
  endfunction

  // Observe one full scan period of both instances
  task automatic capture(output logic [55:0] f0, output logic [55:0] f1,
                         output logic [7:0] s0, output logic [7:0] s1);
    f0 = '0; f1 = '0; s0 = '0; s1 = '0;
    repeat (8 * SCAN_DIV) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (an0 == ~(8'd1 << i)) begin f0[i*7 +: 7] = seg0; s0[i] = 1'b1; end
        if (an1 == ~(8'd1 << i)) begin f1[i*7 +: 7] = seg1; s1[i] = 1'b1; end
      end
    end
  endtask

  task automatic run_conv(input logic [31:0] v, input string tag);
    int          n;
    bit          ov0, ov1;
    logic [55:0] e0, e1, f0, f1;
    logic [7:0]  s0, s1;
    @(negedge clk);
    value  = v;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, 64'(n), 64'd33);
    e0 = model_frame(v, 1'b1, ov0);
    e1 = model_frame(v, 1'b0, ov1);
    chk({tag, ".ovf"},    {ovf1, ovf0}, {ov1, ov0});
    capture(f0, f1, s0, s1);
    chk({tag, ".frame"},    {s0, f0}, {8'hFF, e0});
    chk({tag, ".frame_nb"}, {s1, f1}, {8'hFF, e1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [55:0] e, f0, f1;
    logic [7:0]  s0, s1;
    bit          ov;
    int          bad;
    logic [31:0] dir [10];

    rst_n  = 1'b0;
    value  = 32'd0;
    update = 1'b0;

    // Reset state
    #12;
    chk("reset.outs", {busy0, ovf0, an0, seg0, dp0}, {1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    // Scan sequence after reset: each digit held SCAN_DIV cycles, only digit 0 lit
    for (int k = 1; k <= 8 * SCAN_DIV; k++) begin
      int idx;
      @(negedge clk);
      idx = ((k - 1) / SCAN_DIV) % 8;
      chk($sformatf("scan.k%0d", k), {an0, seg0},
          {~(8'd1 << idx), (idx == 0) ? 7'b1000000 : 7'b1111111});
    end

    // Directed values including the display limits
    dir = '{32'd1234, 32'd1234, -32'sd905, 32'd99999999, -32'sd9999999,
            32'd0, 32'hFFFF_FFFF, 32'd100000000, -32'sd10000000, 32'h7FFF_FFFF};
    foreach (dir[i]) run_conv(dir[i], $sformatf("dir%0d", i));

    // update while busy: one pending conversion, value re-sampled at restart
    e = model_frame(32'd5, 1'b1, ov);
    bad = 0;
    @(negedge clk);
    value  = 32'd5;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      if (k == 9)  begin value = 32'd77; update = 1'b1; end
      if (k == 10) update = 1'b0;
      if (k == 32) chk("pend.busy_e32", busy0, 1'b1);
      if (k == 33) chk("pend.busy_e33", busy0, 1'b0);
      if (k == 34) chk("pend.busy_e34", busy0, 1'b1);
      if (k == 66) chk("pend.busy_e66", busy0, 1'b1);
      if (k == 67) chk("pend.busy_e67", busy0, 1'b0);
      if (k >= 36 && k <= 66) begin
        for (int i = 0; i < 8; i++)
          if (an0 == ~(8'd1 << i) && seg0 != e[i*7 +: 7]) bad++;
      end
    end
    chk("pend.hold_first", 64'(bad), 64'd0);
    capture(f0, f1, s0, s1);
    e = model_frame(32'd77, 1'b1, ov);
    chk("pend.frame", {s0, f0}, {8'hFF, e});

    // Randomized values concentrated around the digit-count boundaries
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999);
        2:       v = $urandom_range(9999990, 10000010);
        default: v = $urandom_range(99999990, 100000010);
      endcase
      if ($urandom_range(0, 1) == 1) v = -v;
      run_conv(v, $sformatf("rnd%0d", r));
    end

    // Most negative value leaves ovf set before the reset test
    run_conv(32'h8000_0000, "minint");

    // Reset mid-conversion with a pending request
    @(negedge clk);
    value  = 32'd42;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 5) update = 1'b1;
      if (k == 6) update = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst.outs", {busy0, ovf0, ovf1, an0, seg0}, {1'b0, 1'b0, 1'b0, 8'hFF, 7'h7F});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy0 !== 1'b0) bad++;
    end
    chk("midrst.no_pending", 64'(bad), 64'd0);
    capture(f0, f1, s0, s1);
    e = model_frame(32'd0, 1'b1, ov);
    chk("midrst.frame",    {s0, f0}, {8'hFF, e});
    chk("midrst.frame_nb", {s1, f1}, {8'hFF, e});
    chk("dp", {dp0, dp1}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_display_driver.md
Name: seg7_display_driver

Overview:
- Display-side consumer of the calculator's 32-bit result bus (displayedNum).
- Converts the signed two's-complement value to BCD with a sequential double-dabble engine.
- Applies leading-zero blanking, minus sign and overflow handling.
- Time-multiplexes the result onto an 8-digit common-anode 7-segment display.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit is enabled during scanning; must be ≥2.
- BLANK_ZEROS, 1: 1 blanks leading zeros; 0 shows all 8 digits zero-padded. Sign and overflow rules are unchanged.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- value  in  32  signed result to show (driven from calculator displayedNum)
- update  in  1  one-cycle strobe: capture value and convert
- busy  out  1  conversion in progress
- ovf  out  1  last committed value did not fit the display
- an  out  8  digit enables, active-low; an[0] is the rightmost digit
- seg  out  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a
- dp  out  1  decimal point, active-low; tied 1 (off)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0; ovf=0; pending=0.
  - Digit registers hold "0" in digit 0, all other digits blank.
  - Scan index=0, scan counter=0; an=8'hFF, seg=7'h7F, dp=1.
- Conversion FSM: IDLE -> CONV -> COMMIT -> IDLE.
- IDLE:
  - Starts a conversion at an edge where update=1 or pending=1.
  - Latches sign=value[31] and mag=|value| as 32-bit unsigned; -2^31 gives 0x8000_0000.
  - Clears the 40-bit BCD register and clears pending; busy=1 from this edge.
- CONV, exactly 32 cycles:
  - Each cycle, every BCD nibble ≥5 gets +3.
  - Then shift {bcd,mag} left by 1.
  - A 5-bit counter ends CONV after the 32nd shift.
- COMMIT, 1 cycle, then IDLE with busy=0:
  - Overflow: positive and any of BCD digits 9..8 nonzero; or negative and any of digits 9..7 nonzero. Sets ovf=1, else ovf=0.
  - Overflow display: digits 2,1,0 = "E","r","r"; other digits blank.
  - Normal display: digits 0..7 from BCD.
    - Leading zeros blanked when BLANK_ZEROS=1; digit 0 is never blanked.
    - If negative, "-" goes in the digit immediately left of the most significant shown digit.
  - Digit registers update only here. The display holds the previous value throughout CONV.
- Latency: update sampled at edge E0; new digits visible from edge E33; busy high after E0 through E33.
- update while busy:
  - Sets pending. No restart and no queueing beyond one.
  - value is re-sampled live at the IDLE edge after COMMIT.
  - Only the latest value is shown.
- update with an unchanged value reconverts and shows an identical result. This is legal.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, E=0000110, r=0101111, blank=1111111
- Scanning, free-running and independent of the FSM:
  - Counter counts 0..SCAN_DIV-1. On wrap, scan index increments modulo 8.
  - an and seg are registered and change together.
  - an = ~(1<<index); seg = code of digit[index].
  - Exactly one an bit is low at any time after the first clock following reset release.
- Reset mid-conversion: aborts; display returns to the reset "0"; pending is discarded.

Test Plan:
- Reset release, then 8×SCAN_DIV cycles with SCAN_DIV=4 -> an cycles FE,FD,FB,…,7F, each held 4 cycles. seg=1000000 only while an=FE; otherwise 1111111.
- value=1234, update pulse -> busy high for 33 cycles. After E33, digits 3..0 show 1,2,3,4; digits 7..4 blank; ovf=0.
- value=-905 (0xFFFF_FC77) -> digits 3..0 = "-",9,0,5; rest blank; ovf=0.
  - Same value with BLANK_ZEROS=0 -> "-" in digit 3, digits 7..4 show 0.
- value=99999999 -> all 8 digits 9, ovf=0.
  - value=100000000 -> "Err" in digits 2..0, ovf=1.
  - value=-9999999 -> "-9999999", ovf=0.
  - value=-10000000 and value=0x8000_0000 -> "Err", ovf=1.
- update(5) at E0, then value=77 with update at E10 -> first commit shows 5 at E33. Second conversion starts at E34 and shows 77 at E67. busy stays high E34–E67.
- update(42), rst asserted at cycle 15 of CONV -> outputs immediately at reset values; after release, display shows "0" and busy=0.
